mxint_block_pack: RTL and testbench

- Re-quantizes a block of per-element (mantissa, exponent) pairs into one MXINT block: one shared exponent plus BLOCK_SIZE aligned signed mantissas.
- Sits downstream of the MXINT exponential and other element-wise operators.
- Packs their per-lane results back into the shared-exponent format consumed by the MXINT accumulators and the softmax normalizer.
- Two-stage elastic pipeline with full valid/ready backpressure.

---
 rtl/mxint_pkg.sv | 22 ++
 rtl/mxint_exp_max_tree.sv | 34 +++
 rtl/mxint_block_pack.sv | 123 ++++++++++++
 tb/tb_mxint_block_pack.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxint_pkg.sv
// Shared MXINT helpers: shift-amount width, saturation bounds and lane exponent type.
package mxint_pkg;

  localparam int unsigned MxintExpWidth = 4;

  typedef logic signed [MxintExpWidth-1:0] mxint_exp_t;

  // Wide enough for (emax - e) plus the fixed fractional realignment.
  function automatic int unsigned mxint_pack_shift_width(input int unsigned in_exp_w,
                                                         input int unsigned in_man_w);
    return $clog2((1 << in_exp_w) + in_man_w) + 1;
  endfunction

  function automatic int mxint_sat_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int mxint_sat_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/mxint_exp_max_tree.sv
// Combinational signed max over BLOCK_SIZE exponents, built as a log-depth comparator tree.
module mxint_exp_max_tree #(
  parameter int unsigned BLOCK_SIZE = 16,
  parameter int unsigned EXP_WIDTH  = 4
) (
  input  logic signed [EXP_WIDTH-1:0] exp_in [BLOCK_SIZE],
  output logic signed [EXP_WIDTH-1:0] exp_max
);

  localparam int unsigned Levels = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 0;
  localparam int unsigned Leaves = 1 << Levels;
  // Padding leaves hold the most negative exponent so they never win.
  localparam logic signed [EXP_WIDTH-1:0] ExpMin = {1'b1, {(EXP_WIDTH - 1){1'b0}}};

  for (genvar l = 0; l <= Levels; l++) begin : g_lvl
    localparam int unsigned Nodes = Leaves >> l;
    logic signed [EXP_WIDTH-1:0] node [Nodes];
    for (genvar n = 0; n < Nodes; n++) begin : g_node
      if (l == 0) begin : g_leaf
        if (n < BLOCK_SIZE) begin : g_in
          assign node[n] = exp_in[n];
        end else begin : g_pad
          assign node[n] = ExpMin;
        end
      end else begin : g_cmp
        assign node[n] = (g_lvl[l-1].node[2*n] > g_lvl[l-1].node[2*n+1]) ?
                         g_lvl[l-1].node[2*n] : g_lvl[l-1].node[2*n+1];
      end
    end
  end

  assign exp_max = g_lvl[Levels].node[0];

endmodule

// File: rtl/mxint_block_pack.sv
// Two-stage elastic MXINT block packer: shared-exponent max, then per-lane align/round/saturate.
// Define MXINT_PACK_ROUND_EN for round-half-up; otherwise lanes truncate (floor).
module mxint_block_pack
  import mxint_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE             = 16,
  parameter int unsigned DATA_IN_MAN_WIDTH      = 10,
  parameter int unsigned DATA_IN_MAN_FRAC_WIDTH = 8,
  parameter int unsigned DATA_IN_EXP_WIDTH      = 4,
  parameter int unsigned DATA_OUT_MAN_WIDTH     = 8,
  parameter int unsigned DATA_OUT_EXP_WIDTH     = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic signed [DATA_IN_MAN_WIDTH-1:0]  mdata_in_0 [BLOCK_SIZE],
  input  logic signed [DATA_IN_EXP_WIDTH-1:0]  edata_in_0 [BLOCK_SIZE],
  input  logic                                 data_in_0_valid,
  output logic                                 data_in_0_ready,
  output logic signed [DATA_OUT_MAN_WIDTH-1:0] mdata_out_0 [BLOCK_SIZE],
  output logic signed [DATA_OUT_EXP_WIDTH-1:0] edata_out_0,
  output logic                                 data_out_0_valid,
  input  logic                                 data_out_0_ready
);

  localparam int unsigned MW       = DATA_IN_MAN_WIDTH;
  localparam int unsigned EW       = DATA_IN_EXP_WIDTH;
  localparam int unsigned OW       = DATA_OUT_MAN_WIDTH;
  localparam int unsigned ShiftW   = mxint_pack_shift_width(EW, MW);
  localparam int unsigned FracDiff = DATA_IN_MAN_FRAC_WIDTH - (OW - 2);
  localparam int          SatMax   = mxint_sat_max(OW);
  localparam int          SatMin   = mxint_sat_min(OW);

  localparam logic signed [MW:0]   WideHi = (MW + 1)'(SatMax);
  localparam logic signed [MW:0]   WideLo = (MW + 1)'(SatMin);
  localparam logic signed [OW-1:0] OutHi  = OW'(SatMax);
  localparam logic signed [OW-1:0] OutLo  = OW'(SatMin);

  logic v1, v2, ld1, ld2;
  logic signed [EW-1:0] emax_c, emax1;
  logic signed [MW-1:0] m1 [BLOCK_SIZE];
  logic signed [EW-1:0] e1 [BLOCK_SIZE];
  logic signed [OW-1:0] lane_d [BLOCK_SIZE];

  assign ld2              = ~v2 | data_out_0_ready;
  assign ld1              = ~v1 | ld2;
  assign data_in_0_ready  = ld1;
  assign data_out_0_valid = v2;

  mxint_exp_max_tree #(
    .BLOCK_SIZE(BLOCK_SIZE),
    .EXP_WIDTH (EW)
  ) u_exp_max (
    .exp_in (edata_in_0),
    .exp_max(emax_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      emax1       <= '0;
      edata_out_0 <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        m1[i]          <= '0;
        e1[i]          <= '0;
        mdata_out_0[i] <= '0;
      end
    end else begin
      if (ld1) begin
        v1 <= data_in_0_valid;
        if (data_in_0_valid) begin
          emax1 <= emax_c;
          m1    <= mdata_in_0;
          e1    <= edata_in_0;
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          mdata_out_0 <= lane_d;
          edata_out_0 <= DATA_OUT_EXP_WIDTH'(emax1);
        end
      end
    end
  end

  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_lane
    logic signed [EW:0]   gap;
    logic [ShiftW-1:0]    d, sh;
    logic signed [MW-1:0] base;
    logic signed [MW:0]   wide;

    assign gap = {emax1[EW-1], emax1} - {e1[i][EW-1], e1[i]};
    assign d   = ShiftW'(gap) + ShiftW'(FracDiff);
    // Clamping at MW already yields pure sign bits, so larger shifts add nothing.
    assign sh  = (d >= ShiftW'(MW)) ? ShiftW'(MW) : d;

`ifdef MXINT_PACK_ROUND_EN
    logic signed [MW-1:0] pre;
    logic                 rbit;

    // Shift by sh-1 first so the last bit shifted out is the rounding bit.
    always_comb begin
      pre  = m1[i];
      base = m1[i];
      rbit = 1'b0;
      if (sh != '0) begin
        pre  = m1[i] >>> (sh - ShiftW'(1));
        base = pre >>> 1;
        rbit = pre[0];
      end
      wide = {base[MW-1], base} + {{MW{1'b0}}, rbit};
    end
`else
    assign base = m1[i] >>> sh;
    assign wide = {base[MW-1], base};
`endif

    assign lane_d[i] = (wide > WideHi) ? OutHi :
                       (wide < WideLo) ? OutLo : wide[OW-1:0];
  end

endmodule

// File: tb/tb_mxint_block_pack.sv
// Randomized and directed bench for mxint_block_pack with a value-level reference model.
module tb_mxint_block_pack;

  localparam int BS = 16, IMW = 10, IFW = 8, IEW = 4, OMW = 8, OEW = 5;
  localparam int XW = BS * OMW + OEW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [IMW-1:0] m_in [BS];
  logic signed [IEW-1:0] e_in [BS];
  logic                  in_valid, in_ready;
  logic signed [OMW-1:0] m_out [BS];
  logic signed [OEW-1:0] e_out;
  logic                  out_valid, out_ready;

  int vectors = 0;
  int errors  = 0;
  int emit_cnt = 0;

  mxint_block_pack dut (
    .clk             (clk),
    .rst             (rst),
    .mdata_in_0      (m_in),
    .edata_in_0      (e_in),
    .data_in_0_valid (in_valid),
    .data_in_0_ready (in_ready),
    .mdata_out_0     (m_out),
    .edata_out_0     (e_out),
    .data_out_0_valid(out_valid),
    .data_out_0_ready(out_ready)
  );

  task automatic check_val(input string tag, input int obs, input int expv);
    vectors++;
    if (obs != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: real-valued alignment to emax with the output fraction, then round/floor and clamp.
  function automatic logic [XW-1:0] model();
    logic [XW-1:0] res;
    int emax, d, m, r;
    emax = -1000;
    for (int i = 0; i < BS; i++) if (int'(e_in[i]) > emax) emax = int'(e_in[i]);
    res = '0;
    for (int i = 0; i < BS; i++) begin
      d = emax - int'(e_in[i]) + IFW - (OMW - 2);
      if (d > IMW) d = IMW;
      m = int'(m_in[i]);
`ifdef MXINT_PACK_ROUND_EN
      r = (d >= 1) ? ((m + (1 << (d - 1))) >>> d) : m;
`else
      r = m >>> d;
`endif
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      res[i*OMW +: OMW] = OMW'(r);
    end
    res[BS*OMW +: OEW] = OEW'(emax);
    return res;
  endfunction

  function automatic logic [XW-1:0] pack_out();
    logic [XW-1:0] res;
    for (int i = 0; i < BS; i++) res[i*OMW +: OMW] = m_out[i];
    res[BS*OMW +: OEW] = e_out;
    return res;
  endfunction

  task automatic cmp_block(input string tag, input logic [XW-1:0] expv);
    check_val({tag, "_exp"}, int'(e_out), int'($signed(expv[BS*OMW +: OEW])));
    for (int i = 0; i < BS; i++)
      check_val({tag, "_lane"}, int'(m_out[i]), int'($signed(expv[i*OMW +: OMW])));
  endtask

  // Scoreboard: inputs and outputs both sampled mid-cycle, where handshakes are settled.
  logic [XW-1:0] exp_q [$];
  logic [XW-1:0] held;
  bit            stalled = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check_val("hold_valid", int'(out_valid), 1);
        cmp_block("hold", held);
      end
      if (in_valid && in_ready) exp_q.push_back(model());
      if (out_valid && out_ready) begin
        check_val("sb_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) cmp_block("sb", exp_q.pop_front());
        emit_cnt++;
      end
      stalled = out_valid && !out_ready;
      held    = pack_out();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int m, input int e);
    for (int i = 0; i < BS; i++) begin
      m_in[i] = IMW'(m);
      e_in[i] = IEW'(e);
    end
  endtask

  // Sends the current block into an empty pipe; returns at the mid-cycle where it is valid.
  task automatic launch(input string tag);
    in_valid = 1'b1;
    @(negedge clk);
    check_val({tag, "_rdy"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_val({tag, "_lat1"}, int'(out_valid), 0);
    @(negedge clk);
    check_val({tag, "_lat2"}, int'(out_valid), 1);
  endtask

  task automatic drain(input string tag);
    int t;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      tick();
      t++;
    end
    check_val({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int t, base_cnt;
    logic acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    fill(0, 0);
    tick();
    @(negedge clk);
    check_val("rst_valid", int'(out_valid), 0);
    check_val("rst_exp", int'(e_out), 0);
    for (int i = 0; i < BS; i++) check_val("rst_lane", int'(m_out[i]), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", int'(in_ready), 1);
    tick();

    fill(256, 0);
    launch("eq");
    check_val("eq_exp", int'(e_out), 0);
    for (int i = 0; i < BS; i++) check_val("eq_lane", int'(m_out[i]), 64);
    tick();

    fill(256, 0);
    e_in[0] = 4'sd3;
    launch("e3");
    check_val("e3_exp", int'(e_out), 3);
    check_val("e3_lane0", int'(m_out[0]), 64);
    check_val("e3_lane1", int'(m_out[1]), 8);
    tick();

    fill(-256, 0);
    e_in[0] = 4'sd7;
    e_in[1] = -4'sd8;
    launch("wide");
    check_val("wide_exp", int'(e_out), 7);
    check_val("wide_lane0", int'(m_out[0]), -64);
`ifdef MXINT_PACK_ROUND_EN
    check_val("wide_lane1", int'(m_out[1]), 0);
`else
    check_val("wide_lane1", int'(m_out[1]), -1);
`endif
    tick();

    fill(258, 0);
    launch("r258");
`ifdef MXINT_PACK_ROUND_EN
    check_val("r258_lane", int'(m_out[5]), 65);
`else
    check_val("r258_lane", int'(m_out[5]), 64);
`endif
    tick();

    fill(511, 0);
    launch("s511");
    check_val("s511_lane", int'(m_out[9]), 127);
    tick();

    fill(-512, 0);
    launch("sneg");
    check_val("sneg_lane", int'(m_out[15]), -128);
    tick();

    // Backpressure: four back-to-back blocks while the sink stalls for five cycles.
    base_cnt  = emit_cnt;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          fill(64 * (k + 1), 0);
          in_valid = 1'b1;
          @(negedge clk);
          t = 0;
          while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
          end
          check_val("bp_accept_in_time", int'(t < 50), 1);
          tick();
          if (k == 1) begin
            @(negedge clk);
            check_val("bp_ready_drop", int'(in_ready), 0);
          end
        end
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    t = 0;
    while (emit_cnt < base_cnt + 4 && t < 100) begin
      tick();
      t++;
    end
    repeat (4) tick();
    check_val("bp_emitted", emit_cnt - base_cnt, 4);
    check_val("bp_queue_empty", exp_q.size(), 0);

    // Reset with both stages full.
    out_ready = 1'b0;
    fill(100, 1);
    in_valid = 1'b1;
    tick();
    fill(-100, 2);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_val("mid_full", int'(out_valid && !in_ready), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("mid_rst_valid", int'(out_valid), 0);
    check_val("mid_rst_exp", int'(e_out), 0);
    for (int i = 0; i < BS; i++) check_val("mid_rst_lane", int'(m_out[i]), 0);
    out_ready = 1'b1;
    tick();
    fill(256, 0);
    e_in[3] = 4'sd1;
    launch("fresh");
    check_val("fresh_exp", int'(e_out), 1);
    check_val("fresh_lane3", int'(m_out[3]), 64);
    check_val("fresh_lane0", int'(m_out[0]), 32);
    tick();

    // Random traffic with random sink stalls.
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < BS; i++) begin
          m_in[i] = IMW'($urandom);
          e_in[i] = ($urandom_range(0, 1) != 0) ? IEW'($urandom) : IEW'($urandom_range(0, 3));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
    end
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
